// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arbitrated multiplexer.
// Configuration macro: ARB_MUX_RR_EN selects round-robin (defined) or fixed priority (undefined).
package arb_mux_pkg;

    localparam int DEFAULT_WIDTH    = 32;
    localparam int DEFAULT_CHANNELS = 4;
    localparam int MAX_CHANNELS     = 16;

    // Callers zero-extend their grant vector to MAX_CHANNELS bits and narrow the result.
    function automatic logic [3:0] onehot_to_idx(input logic [MAX_CHANNELS-1:0] onehot);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_CHANNELS; i++) begin
            if (onehot[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// One-hot request arbiter: round-robin with a rotating pointer when ARB_MUX_RR_EN is defined,
// otherwise stateless fixed priority with the lowest index winning.
module rr_arbiter #(
    parameter int CHANNELS = 4,
    localparam int SELW = $clog2(CHANNELS)
) (
`ifdef ARB_MUX_RR_EN
    input  logic                clk,
    input  logic                rst,
`endif
    input  logic [CHANNELS-1:0] req,
    input  logic                en,
    output logic [CHANNELS-1:0] grant
);

`ifdef ARB_MUX_RR_EN
    logic [SELW-1:0] r_ptr;
    logic [SELW-1:0] w_ptr_nxt;
    logic [SELW-1:0] w_idx;
    logic            w_found;

    // Search ptr, ptr+1, ... modulo CHANNELS so ptr stays below CHANNELS for any count.
    always_comb begin
        grant     = '0;
        w_ptr_nxt = r_ptr;
        w_idx     = '0;
        w_found   = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_idx = SELW'((int'(r_ptr) + k) % CHANNELS);
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_ptr_nxt    = SELW'((int'(r_ptr) + k + 1) % CHANNELS);
                w_found      = 1'b1;
            end
        end
        if (!en) begin
            grant = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (en && (|req)) begin
            r_ptr <= w_ptr_nxt;
        end
    end
`else
    // Isolate the lowest set request bit.
    always_comb begin
        grant = '0;
        if (en) begin
            grant = req & (~req + CHANNELS'(1));
        end
    end
`endif

endmodule

// File: rtl/arb_mux.sv
// N-channel arbitrated multiplexer with a registered output stage.
// Arbitration mode is chosen by ARB_MUX_RR_EN (round-robin) versus fixed priority.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int CHANNELS = DEFAULT_CHANNELS,
    localparam int SELW    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_sel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    // Handshake: a beat moves on any edge where valid && ready; producers hold valid and data
    // stable until granted, and the output item is held until out_ready is seen with out_valid.
    logic                r_valid;
    logic [WIDTH-1:0]    r_data;
    logic [SELW-1:0]     r_sel;
    logic                w_free;
    logic                w_en;
    logic [CHANNELS-1:0] w_grant;
    logic [WIDTH-1:0]    w_data;
    logic [SELW-1:0]     w_sel;

    assign w_free = !r_valid || out_ready;
    assign w_en   = w_free && !rst;

    rr_arbiter #(
        .CHANNELS(CHANNELS)
    ) u_arb (
`ifdef ARB_MUX_RR_EN
        .clk  (clk),
        .rst  (rst),
`endif
        .req  (in_valid),
        .en   (w_en),
        .grant(w_grant)
    );

    always_comb begin
        w_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant[i]) begin
                w_data = w_data | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_sel = SELW'(onehot_to_idx(MAX_CHANNELS'(w_grant)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
        end else if (|w_grant) begin
            r_valid <= 1'b1;
            r_data  <= w_data;
            r_sel   <= w_sel;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign in_ready  = w_grant;
    assign out_data  = r_data;
    assign out_sel   = r_sel;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: a 4x32 instance for the main scenarios and a 3x8 instance for pointer wrap.
module tb_arb_mux;

`ifdef ARB_MUX_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;
    logic         out_valid;
    logic         out_ready;

    logic [23:0]  in_data3;
    logic [2:0]   in_valid3;
    logic [2:0]   in_ready3;
    logic [7:0]   out_data3;
    logic [1:0]   out_sel3;
    logic         out_valid3;
    logic         out_ready3;

    int total;
    int bad;

    arb_mux #(.WIDTH(32), .CHANNELS(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
    );

    arb_mux #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_sel(out_sel3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        in_data    = '0;
        in_valid   = 4'hF;
        out_ready  = 1'b0;
        in_data3   = {8'hA2, 8'hA1, 8'hA0};
        in_valid3  = 3'b000;
        out_ready3 = 1'b1;

        // Reset state, including in_ready held low while rst is high.
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_sel", 64'(out_sel), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single request on channel 2.
        in_valid = 4'b0100;
        in_data[2*32 +: 32] = 32'hDEAD_BEEF;
        out_ready = 1'b1;
        #1;
        chk("single_in_ready", 64'(in_ready), 64'h4);
        tick();
        chk("single_out_data", 64'(out_data), 64'hDEAD_BEEF);
        chk("single_out_sel", 64'(out_sel), 64'd2);
        chk("single_out_valid", 64'(out_valid), 64'd1);

        // Hold the item, then reset asynchronously between edges.
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        tick();
        chk("hold_out_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_out_data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // All four valid continuously with out_ready high.
        for (int i = 0; i < 4; i++) begin
            in_data[i*32 +: 32] = 32'h1000_0000 + 32'(i);
        end
        in_valid  = 4'hF;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stream_in_ready", 64'(in_ready), RR ? 64'(4'b0001 << (c % 4)) : 64'h1);
            tick();
            chk("stream_out_sel", 64'(out_sel), RR ? 64'(c % 4) : 64'd0);
            chk("stream_out_data", 64'(out_data), RR ? 64'(32'h1000_0000 + 32'(c % 4)) : 64'h1000_0000);
            chk("stream_out_valid", 64'(out_valid), 64'd1);
        end

        // Back-pressure on an item from channel 1, then reload from channel 3 on release.
        in_valid = 4'b0010;
        #1;
        chk("bp_load_in_ready", 64'(in_ready), 64'h2);
        tick();
        chk("bp_load_out_sel", 64'(out_sel), 64'd1);
        out_ready = 1'b0;
        in_valid  = 4'hF;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            tick();
            chk("bp_out_data", 64'(out_data), 64'h1000_0001);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        in_valid  = 4'b1000;
        #1;
        chk("bp_release_in_ready", 64'(in_ready), 64'h8);
        tick();
        chk("bp_release_out_sel", 64'(out_sel), 64'd3);
        chk("bp_release_out_data", 64'(out_data), 64'h1000_0003);
        chk("bp_release_out_valid", 64'(out_valid), 64'd1);

        // Channel 1 withdraws while blocked and must never be granted.
        out_ready = 1'b0;
        in_valid  = 4'b0011;
        #1;
        chk("drop_blocked_in_ready", 64'(in_ready), 64'd0);
        tick();
        in_valid = 4'b0001;
        in_data[0 +: 32]  = 32'hC0DE_0000;
        in_data[32 +: 32] = 32'hBAD0_0001;
        out_ready = 1'b1;
        #1;
        chk("drop_in_ready", 64'(in_ready), 64'h1);
        tick();
        chk("drop_out_sel", 64'(out_sel), 64'd0);
        chk("drop_out_data", 64'(out_data), 64'hC0DE_0000);
        in_valid = 4'b0000;
        #1;
        chk("drain_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("drain_out_valid", 64'(out_valid), 64'd0);
        chk("drain_out_data_hold", 64'(out_data), 64'hC0DE_0000);
        chk("drain_out_sel_hold", 64'(out_sel), 64'd0);

        // Pointer wrap with three channels.
        in_valid3 = 3'b100;
        #1;
        chk("wrap_first_in_ready", 64'(in_ready3), 64'h4);
        tick();
        chk("wrap_first_out_sel", 64'(out_sel3), 64'd2);
        chk("wrap_first_out_data", 64'(out_data3), 64'hA2);
        in_valid3 = 3'b101;
        #1;
        chk("wrap_in_ready", 64'(in_ready3), 64'h1);
        tick();
        chk("wrap_out_sel", 64'(out_sel3), 64'd0);
        chk("wrap_out_data", 64'(out_data3), 64'hA0);
        in_valid3 = 3'b011;
        #1;
        chk("wrap_next_in_ready", 64'(in_ready3), RR ? 64'h2 : 64'h1);
        tick();
        chk("wrap_next_out_sel", 64'(out_sel3), RR ? 64'd1 : 64'd0);
        chk("wrap_next_out_valid", 64'(out_valid3), 64'd1);
        in_valid3 = 3'b000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
